// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle main control FSM; optional ILLEGAL_TRAP_EN macro traps unknown opcodes into HALT
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       MemReq,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       MemTimeout
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WMAX = CW'(MEM_WAIT_MAX);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, HALT
  } state_t;
  state_t state, state_next;
  logic [CW-1:0] wait_cnt;
  logic waiting;
  logic [2:0] alu_op;
  assign waiting = (state == FETCH || state == MEMREAD || state == MEMWRITE) && !mem_ready;
  // funct decode shared by EXECR/EXECI; sub only for register ops with funct7b5
  assign alu_op = funct3 == 3'b000 ? ((state == EXECR && funct7b5) ? 3'b001 : 3'b000) :
                  funct3 == 3'b010 ? 3'b101 :
                  funct3 == 3'b110 ? 3'b011 :
                  funct3 == 3'b111 ? 3'b010 : 3'b000;
  // state register, saturating memory wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) wait_cnt <= '0;
      else if (waiting && wait_cnt != WMAX) wait_cnt <= wait_cnt + 1'b1;
      if (waiting && wait_cnt >= WMAX - 1'b1) MemTimeout <= 1'b1;
    end
  end
  // next state and Moore outputs; everything forced low while reset is asserted
  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    MemReq     = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 2'b00;
    if (rst_n) begin
      case (state)
        FETCH: begin
          MemReq     = 1'b1;
          ALUSrcB    = 2'b10;
          ResultSrc  = 2'b10;
          IRWrite    = mem_ready;
          PCWrite    = mem_ready;
          state_next = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b01;
          ImmSrc     = 2'b10;
          state_next = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
                       op == 7'b0110011 ? EXECR :
                       op == 7'b0010011 ? EXECI :
                       op == 7'b1100011 ? BRANCH :
                       op == 7'b1101111 ? JAL :
`ifdef ILLEGAL_TRAP_EN
                       HALT;
`else
                       FETCH;
`endif
        end
        MEMADR: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ImmSrc     = op == 7'b0100011 ? 2'b01 : 2'b00;
          state_next = op == 7'b0100011 ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          MemReq     = 1'b1;
          AdrSrc     = 1'b1;
          state_next = mem_ready ? MEMWB : MEMREAD;
        end
        MEMWB: begin
          ResultSrc  = 2'b01;
          RegWrite   = 1'b1;
          state_next = FETCH;
        end
        MEMWRITE: begin
          MemReq     = 1'b1;
          AdrSrc     = 1'b1;
          MemWrite   = 1'b1;
          state_next = mem_ready ? FETCH : MEMWRITE;
        end
        EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = alu_op;
          state_next = ALUWB;
        end
        EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = alu_op;
          state_next = ALUWB;
        end
        ALUWB: begin
          RegWrite   = 1'b1;
          state_next = FETCH;
        end
        BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = 3'b001;
          ImmSrc     = 2'b10;
          PCWrite    = Zero;
          state_next = FETCH;
        end
        JAL: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b10;
          ImmSrc     = 2'b11;
          PCWrite    = 1'b1;
          state_next = ALUWB;
        end
        default: state_next = state;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n, funct7b5, Zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite, MemTimeout;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  int total = 0;
  int bad = 0;
  // bundle order: PCWrite AdrSrc MemWrite MemReq IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc
  localparam logic [16:0] ZERO_O    = 17'b0_0_0_0_0_0_00_00_00_000_00;
  localparam logic [16:0] FETCH_GO  = 17'b1_0_0_1_1_0_10_00_10_000_00;
  localparam logic [16:0] FETCH_W   = 17'b0_0_0_1_0_0_10_00_10_000_00;
  localparam logic [16:0] DECODE_O  = 17'b0_0_0_0_0_0_00_01_01_000_10;
  localparam logic [16:0] EXECR_ADD = 17'b0_0_0_0_0_0_00_10_00_000_00;
  localparam logic [16:0] EXECR_SUB = 17'b0_0_0_0_0_0_00_10_00_001_00;
  localparam logic [16:0] EXECR_SLT = 17'b0_0_0_0_0_0_00_10_00_101_00;
  localparam logic [16:0] EXECI_ADD = 17'b0_0_0_0_0_0_00_10_01_000_00;
  localparam logic [16:0] EXECI_OR  = 17'b0_0_0_0_0_0_00_10_01_011_00;
  localparam logic [16:0] ALUWB_O   = 17'b0_0_0_0_0_1_00_00_00_000_00;
  localparam logic [16:0] MEMADR_LW = 17'b0_0_0_0_0_0_00_10_01_000_00;
  localparam logic [16:0] MEMADR_SW = 17'b0_0_0_0_0_0_00_10_01_000_01;
  localparam logic [16:0] MEMREAD_O = 17'b0_1_0_1_0_0_00_00_00_000_00;
  localparam logic [16:0] MEMWB_O   = 17'b0_0_0_0_0_1_01_00_00_000_00;
  localparam logic [16:0] MEMWR_O   = 17'b0_1_1_1_0_0_00_00_00_000_00;
  localparam logic [16:0] BR_TAKEN  = 17'b1_0_0_0_0_0_00_10_00_001_10;
  localparam logic [16:0] BR_NOT    = 17'b0_0_0_0_0_0_00_10_00_001_10;
  localparam logic [16:0] JAL_O     = 17'b1_0_0_0_0_0_00_01_10_000_11;
  wire [16:0] outs = {PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite,
                      ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc};

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .MemReq(MemReq), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .MemTimeout(MemTimeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_to(input string tag, input logic exp);
    total++;
    assert (MemTimeout === exp) else begin
      bad++;
      $error("FAIL %s MemTimeout observed=%b expected=%b", tag, MemTimeout, exp);
    end
  endtask

  // check the current state's outputs, then advance one clock
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1;
    chk(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("reset_outs", outs, ZERO_O);
    chk_to("reset_to", 1'b0);
    rst_n = 1'b1;
    // add x3,x1,x2
    op = 7'b0110011; mem_ready = 1'b1;
    cyc("add_fetch", FETCH_GO);
    mem_ready = 1'b0;
    cyc("add_decode", DECODE_O);
    cyc("add_execr", EXECR_ADD);
    cyc("add_aluwb", ALUWB_O);
    // lw with three wait cycles in MEMREAD
    op = 7'b0000011; mem_ready = 1'b1;
    cyc("lw_fetch", FETCH_GO);
    mem_ready = 1'b0;
    cyc("lw_decode", DECODE_O);
    cyc("lw_memadr", MEMADR_LW);
    cyc("lw_memread_w1", MEMREAD_O);
    cyc("lw_memread_w2", MEMREAD_O);
    cyc("lw_memread_w3", MEMREAD_O);
    mem_ready = 1'b1;
    cyc("lw_memread_go", MEMREAD_O);
    mem_ready = 1'b0;
    cyc("lw_memwb", MEMWB_O);
    // sw with two wait cycles in MEMWRITE
    op = 7'b0100011; mem_ready = 1'b1;
    cyc("sw_fetch", FETCH_GO);
    mem_ready = 1'b0;
    cyc("sw_decode", DECODE_O);
    cyc("sw_memadr", MEMADR_SW);
    cyc("sw_memwr_w1", MEMWR_O);
    cyc("sw_memwr_w2", MEMWR_O);
    mem_ready = 1'b1;
    cyc("sw_memwr_go", MEMWR_O);
    mem_ready = 1'b0;
    cyc("sw_back_fetch", FETCH_W);
    // beq taken then not taken
    op = 7'b1100011; Zero = 1'b1; mem_ready = 1'b1;
    cyc("beq_t_fetch", FETCH_GO);
    mem_ready = 1'b0;
    cyc("beq_t_decode", DECODE_O);
    cyc("beq_t_branch", BR_TAKEN);
    Zero = 1'b0; mem_ready = 1'b1;
    cyc("beq_n_fetch", FETCH_GO);
    mem_ready = 1'b0;
    cyc("beq_n_decode", DECODE_O);
    cyc("beq_n_branch", BR_NOT);
    // jal
    op = 7'b1101111; mem_ready = 1'b1;
    cyc("jal_fetch", FETCH_GO);
    mem_ready = 1'b0;
    cyc("jal_decode", DECODE_O);
    cyc("jal_jal", JAL_O);
    cyc("jal_aluwb", ALUWB_O);
    // sub
    op = 7'b0110011; funct7b5 = 1'b1; mem_ready = 1'b1;
    cyc("sub_fetch", FETCH_GO);
    mem_ready = 1'b0;
    cyc("sub_decode", DECODE_O);
    cyc("sub_execr", EXECR_SUB);
    cyc("sub_aluwb", ALUWB_O);
    // slt
    funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    cyc("slt_fetch", FETCH_GO);
    mem_ready = 1'b0;
    cyc("slt_decode", DECODE_O);
    cyc("slt_execr", EXECR_SLT);
    cyc("slt_aluwb", ALUWB_O);
    // addi with funct7b5 set still adds
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1; mem_ready = 1'b1;
    cyc("addi_fetch", FETCH_GO);
    mem_ready = 1'b0;
    cyc("addi_decode", DECODE_O);
    cyc("addi_execi", EXECI_ADD);
    cyc("addi_aluwb", ALUWB_O);
    // ori
    funct3 = 3'b110; funct7b5 = 1'b0; mem_ready = 1'b1;
    cyc("ori_fetch", FETCH_GO);
    mem_ready = 1'b0;
    cyc("ori_decode", DECODE_O);
    cyc("ori_execi", EXECI_OR);
    cyc("ori_aluwb", ALUWB_O);
    // fetch stall: timeout after 15 waiting cycles, sticky
    chk_to("to_before", 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cyc("fetch_wait", FETCH_W);
      chk_to($sformatf("to_wait_%0d", i), i >= 15);
    end
    // reset during the wait
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", outs, ZERO_O);
    @(posedge clk); #1;
    chk_to("rst_mid_to", 1'b0);
    rst_n = 1'b1;
    // illegal opcode
    op = 7'b1111111; mem_ready = 1'b1;
    cyc("ill_fetch", FETCH_GO);
    mem_ready = 1'b0;
    cyc("ill_decode", DECODE_O);
`ifdef ILLEGAL_TRAP_EN
    mem_ready = 1'b1;
    cyc("ill_halt1", ZERO_O);
    cyc("ill_halt2", ZERO_O);
`else
    cyc("ill_back_fetch", FETCH_W);
    mem_ready = 1'b1;
    cyc("ill_refetch", FETCH_GO);
`endif
    chk_to("final_to", 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
